// File: rtl/shr_result_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shr_result_skid_reg_pkg
//  Description : State encoding and default width shared by the skid-buffered
//                datapath output stages (SHR, SHL, ADD, MUL).
//  Revision    : 1.0  initial release
// ============================================================================
package shr_result_skid_reg_pkg;

    localparam int DEFAULT_DATAWIDTH = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

    // Occupancy implied by a state; the unused 2'b11 code reports as empty.
    function automatic logic [1:0] state_count(input skid_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/shr_result_skid_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : shr_result_skid_reg_if
//  Description : Valid/ready handshake bundle between shifter, skid stage and
//                consumer. The slave modport is the skid stage's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface shr_result_skid_reg_if
    import shr_result_skid_reg_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) ();

    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           count;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  count
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output count
    );

endinterface
`default_nettype wire

// File: rtl/shr_result_skid_reg_entry.sv
`default_nettype none
// ============================================================================
//  Module      : shr_result_skid_reg_entry
//  Description : One data register of the skid pair: load enable, sync reset.
//  Revision    : 1.0  initial release
// ============================================================================
module shr_result_skid_reg_entry #(
    parameter int DATAWIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_load,
    input  wire logic [DATAWIDTH-1:0] i_data,
    output logic      [DATAWIDTH-1:0] o_data
);

    logic [DATAWIDTH-1:0] data_q;
    logic [DATAWIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_load) begin
            data_d = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/shr_result_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : shr_result_skid_reg
//  Description : Two-entry valid/ready skid buffer registering the SHR result;
//                all outputs come straight from flops.
//  Revision    : 1.0  initial release
// ============================================================================
module shr_result_skid_reg
    import shr_result_skid_reg_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  wire logic            Clk,
    input  wire logic            Rst,
    shr_result_skid_reg_if.slave bus
);

    skid_state_e          state_q;
    skid_state_e          state_d;
    logic                 in_ready_q;
    logic                 in_ready_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [1:0]           count_q;
    logic [1:0]           count_d;

    logic                 main_load;
    logic [DATAWIDTH-1:0] main_d;
    logic [DATAWIDTH-1:0] main_q;
    logic                 skid_load;
    logic [DATAWIDTH-1:0] skid_q;

    logic                 acc_in;
    logic                 acc_out;

    assign acc_in  = bus.in_valid && in_ready_q;
    assign acc_out = out_valid_q && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_d    = bus.in_data;
        skid_load = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (acc_in) begin
                    main_load = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc_in && acc_out) begin
                    main_load = 1'b1;
                end else if (acc_in) begin
                    skid_load = 1'b1;
                    state_d   = ST_TWO;
                end else if (acc_out) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // The older word in main leaves; the skid word moves up.
                if (acc_out) begin
                    main_load = 1'b1;
                    main_d    = skid_q;
                    state_d   = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Handshake outputs are the decode of the next state, so they are
        // registered alongside it and never depend combinationally on inputs.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
        count_d     = state_count(state_d);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    shr_result_skid_reg_entry #(
        .DATAWIDTH (DATAWIDTH)
    ) u_main_reg (
        .clk    (Clk),
        .rst    (Rst),
        .i_load (main_load),
        .i_data (main_d),
        .o_data (main_q)
    );

    shr_result_skid_reg_entry #(
        .DATAWIDTH (DATAWIDTH)
    ) u_skid_reg (
        .clk    (Clk),
        .rst    (Rst),
        .i_load (skid_load),
        .i_data (bus.in_data),
        .o_data (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shr_result_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shr_result_skid_reg
//  Description : Scoreboard bench for the SHR result skid register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shr_result_skid_reg;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shr_result_skid_reg_if #(.DATAWIDTH(DW)) bus ();

    shr_result_skid_reg #(
        .DATAWIDTH (DW)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] exp_q[$];
    int            model_cnt  = 0;
    bit            model_init = 0;
    bit            m_acc_in;
    bit            m_acc_out;
    int            n_checks   = 0;
    int            n_errors   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference occupancy model: decides acceptance from bench-driven inputs
    // only and pushes every word it expects the DUT to take.
    always @(posedge clk) begin
        if (rst) begin
            model_cnt  = 0;
            exp_q.delete();
            model_init = 1;
        end else if (model_init) begin
            m_acc_in  = bus.in_valid && (model_cnt < 2);
            m_acc_out = bus.out_ready && (model_cnt > 0);
            if (m_acc_in) exp_q.push_back(bus.in_data);
            model_cnt = model_cnt + int'(m_acc_in) - int'(m_acc_out);
        end
    end

    // Monitor: status flags every cycle, data whenever the DUT presents it.
    always @(negedge clk) begin
        if (model_init) begin
            check("count",     32'(bus.count),     32'(model_cnt));
            check("in_ready",  32'(bus.in_ready),  32'(model_cnt != 2));
            check("out_valid", 32'(bus.out_valid), 32'(model_cnt != 0));
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_data: got 0x%0h, expected no word at %0t", bus.out_data, $time);
                end else begin
                    check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00FF;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b0);

        // single pass
        step(1'b1, 16'h0F0F, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);

        // backpressure fill; the third word must be refused
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        repeat (3) step(1'b0, 16'h0000, 1'b1);

        // streaming at full rate
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1);
        repeat (2) step(1'b0, 16'h0000, 1'b1);

        // simultaneous accept/consume while holding one word
        step(1'b1, 16'hAAAA, 1'b0);
        step(1'b1, 16'hBBBB, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);

        // reset while full discards both held words
        step(1'b1, 16'hC1C1, 1'b0);
        step(1'b1, 16'hC2C2, 1'b0);
        rst = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        step(1'b1, 16'h5A5A, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);

        begin
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                step(1'b0, 16'h0000, 1'b1);
                budget--;
            end
        end
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
